// File: rtl/bitrev_reorder_buf_pkg.sv
// Shared types and helpers for the bit-reversal reorder buffer.
// Holds the FSM state encoding and the frame-length mask helper.
package bitrev_reorder_buf_pkg;

  typedef enum logic {
    StFill  = 1'b0,
    StDrain = 1'b1
  } state_e;

  // Index of the last word in a frame of 2^m words.
  function automatic int unsigned len_mask(input int unsigned m);
    return (32'd1 << m) - 32'd1;
  endfunction

endpackage

// File: rtl/bitrev_addr.sv
// Reverses the low m bits of an index and clears the bits above them.
module bitrev_addr #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned MW    = $clog2(LOG2N + 1)
) (
  input  logic [LOG2N-1:0] idx,
  input  logic [MW-1:0]    m,
  output logic [LOG2N-1:0] addr
);

  // Output bit i takes input bit m-1-i; nothing is selected when i >= m.
  always_comb begin
    addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      for (int j = 0; j < LOG2N; j++) begin
        if ((i + j + 1) == int'(m)) addr[i] = idx[j];
      end
    end
  end

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Single-buffer reorder stage. It fills a frame that arrives in bit-reversed order,
// then drains the frame in natural order. Both sides use valid/ready handshakes.
module bitrev_reorder_buf
  import bitrev_reorder_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LOG2N  = 3,
  localparam int unsigned MW    = $clog2(LOG2N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MW-1:0]     cfg_log2n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned N = 1 << LOG2N;

  state_e            state_q;
  logic [LOG2N-1:0]  wr_cnt_q;
  logic [LOG2N-1:0]  rd_cnt_q;
  logic [MW-1:0]     m_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] mem [N];

  logic              in_fire;
  logic              out_fire;
  logic [MW-1:0]     m_eff;
  logic [MW-1:0]     m_wr;
  logic [LOG2N-1:0]  wr_addr;
  logic              wr_last;
  logic              rd_last;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  assign m_eff = (cfg_log2n > MW'(LOG2N)) ? MW'(LOG2N) : cfg_log2n;
  // The first word has to be steered before m_q can hold the new frame length.
  assign m_wr  = (wr_cnt_q == '0) ? m_eff : m_q;

  assign wr_last = (wr_cnt_q == LOG2N'(len_mask(32'(m_wr))));
  assign rd_last = (rd_cnt_q == LOG2N'(len_mask(32'(m_q))));

  bitrev_addr #(
    .LOG2N(LOG2N),
    .MW   (MW)
  ) u_bitrev_addr (
    .idx (wr_cnt_q),
    .m   (m_wr),
    .addr(wr_addr)
  );

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      m_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          // in_ready is only low in FILL on the first cycle after reset.
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_fire) begin
            if (wr_cnt_q == '0) m_q <= m_eff;
            if (wr_last) begin
              wr_cnt_q    <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= StDrain;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_fire) begin
            if (rd_last) begin
              rd_cnt_q    <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StFill;
            end else begin
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem[rd_cnt_q];
  assign out_last  = out_valid_q & rd_last;

endmodule
